// File: rtl/t03_combat_resolver.sv
// Combat resolver: turns held attacks into hits or blocks after a windup, tracks both health
// counters and runs the round FSM (fight / P1 win / P2 win / draw).
module t03_combat_resolver #(
  parameter int unsigned         HEALTH_W   = 7,
  parameter logic [HEALTH_W-1:0] MAX_HEALTH = 7'd100,
  parameter logic [HEALTH_W-1:0] DAMAGE     = 7'd10,
  parameter logic [7:0]          WINDUP     = 8'd4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                finished,
  input  logic                restart,
  input  logic [1:0]          p1_state,
  input  logic [1:0]          p2_state,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_hit,
  output logic                p2_hit,
  output logic                p1_blocked,
  output logic                p2_blocked,
  output logic [1:0]          game_state
);

  typedef enum logic [1:0] {
    StFight = 2'b00,
    StP1Win = 2'b01,
    StP2Win = 2'b10,
    StDraw  = 2'b11
  } game_e;

  localparam logic [1:0] PsAttack = 2'b01;
  localparam logic [1:0] PsBlock  = 2'b10;

  // Index 0 is player 1, index 1 is player 2.
  logic [1:0]          st      [2];
  logic [1:0]          prev_q  [2];
  logic [1:0]          prev_d  [2];
  logic                armed_q [2];
  logic                armed_d [2];
  logic [7:0]          cnt_q   [2];
  logic [7:0]          cnt_d   [2];
  logic [HEALTH_W-1:0] health_q[2];
  logic [HEALTH_W-1:0] health_d[2];
  logic                hit_q   [2];
  logic                hit_d   [2];
  logic                blk_q   [2];
  logic                blk_d   [2];
  logic [8:0]          inc     [2];
  game_e               game_q, game_d;

  assign st[0] = p1_state;
  assign st[1] = p2_state;

  always_comb begin
    game_d = game_q;
    for (int i = 0; i < 2; i++) begin
      prev_d[i]   = prev_q[i];
      armed_d[i]  = armed_q[i];
      cnt_d[i]    = cnt_q[i];
      health_d[i] = health_q[i];
      hit_d[i]    = 1'b0;
      blk_d[i]    = 1'b0;
      inc[i]      = {1'b0, cnt_q[i]} + 9'd1;
    end

    if (restart) begin
      game_d = StFight;
      for (int i = 0; i < 2; i++) begin
        prev_d[i]   = 2'b00;
        armed_d[i]  = 1'b0;
        cnt_d[i]    = 8'd0;
        health_d[i] = MAX_HEALTH;
      end
    end else if (finished) begin
      for (int i = 0; i < 2; i++) prev_d[i] = st[i];
      if (game_q == StFight) begin
        for (int i = 0; i < 2; i++) begin
          if (st[i] == PsAttack && prev_q[i] != PsAttack) begin
            armed_d[i] = 1'b1;
            cnt_d[i]   = 8'd0;
          end else if (armed_q[i] && st[i] == PsAttack) begin
            cnt_d[i] = inc[i][7:0];
            if (inc[i] == {1'b0, WINDUP}) begin
              armed_d[i] = 1'b0;
              // Block check uses the opponent's input on this same tick.
              if (st[1-i] == PsBlock) begin
                blk_d[1-i] = 1'b1;
              end else begin
                hit_d[1-i]    = 1'b1;
                health_d[1-i] = (health_q[1-i] < DAMAGE) ? '0 : health_q[1-i] - DAMAGE;
              end
            end
          end else if (armed_q[i]) begin
            armed_d[i] = 1'b0;
          end
        end
        if (health_d[0] == '0 && health_d[1] == '0) game_d = StDraw;
        else if (health_d[1] == '0)                 game_d = StP1Win;
        else if (health_d[0] == '0)                 game_d = StP2Win;
      end else begin
        for (int i = 0; i < 2; i++) armed_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      game_q <= StFight;
      for (int i = 0; i < 2; i++) begin
        prev_q[i]   <= 2'b00;
        armed_q[i]  <= 1'b0;
        cnt_q[i]    <= 8'd0;
        health_q[i] <= MAX_HEALTH;
        hit_q[i]    <= 1'b0;
        blk_q[i]    <= 1'b0;
      end
    end else begin
      game_q <= game_d;
      for (int i = 0; i < 2; i++) begin
        prev_q[i]   <= prev_d[i];
        armed_q[i]  <= armed_d[i];
        cnt_q[i]    <= cnt_d[i];
        health_q[i] <= health_d[i];
        hit_q[i]    <= hit_d[i];
        blk_q[i]    <= blk_d[i];
      end
    end
  end

  assign p1_health  = health_q[0];
  assign p2_health  = health_q[1];
  assign p1_hit     = hit_q[0];
  assign p2_hit     = hit_q[1];
  assign p1_blocked = blk_q[0];
  assign p2_blocked = blk_q[1];
  assign game_state = game_q;

endmodule

// File: tb/tb_t03_combat_resolver.sv
// Directed bench for t03_combat_resolver; a second instance with a small MAX_HEALTH covers
// saturation below DAMAGE and the draw outcome.
module tb_t03_combat_resolver;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       finished = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] p1_state = 2'b00;
  logic [1:0] p2_state = 2'b00;

  logic [6:0] p1_health, p2_health, s_p1_health, s_p2_health;
  logic       p1_hit, p2_hit, p1_blocked, p2_blocked;
  logic       s_p1_hit, s_p2_hit, s_p1_blocked, s_p2_blocked;
  logic [1:0] game_state, s_game_state;

  int n_vec = 0;
  int n_bad = 0;
  int n_p1h, n_p2h, n_p1b, n_p2b;

  always #5 clk = ~clk;

  t03_combat_resolver u_dut (
    .clk       (clk),
    .nrst      (nrst),
    .finished  (finished),
    .restart   (restart),
    .p1_state  (p1_state),
    .p2_state  (p2_state),
    .p1_health (p1_health),
    .p2_health (p2_health),
    .p1_hit    (p1_hit),
    .p2_hit    (p2_hit),
    .p1_blocked(p1_blocked),
    .p2_blocked(p2_blocked),
    .game_state(game_state)
  );

  t03_combat_resolver #(.MAX_HEALTH(7'd25)) u_sat (
    .clk       (clk),
    .nrst      (nrst),
    .finished  (finished),
    .restart   (restart),
    .p1_state  (p1_state),
    .p2_state  (p2_state),
    .p1_health (s_p1_health),
    .p2_health (s_p2_health),
    .p1_hit    (s_p1_hit),
    .p2_hit    (s_p2_hit),
    .p1_blocked(s_p1_blocked),
    .p2_blocked(s_p2_blocked),
    .game_state(s_game_state)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_pulses();
    n_p1h = 0; n_p2h = 0; n_p1b = 0; n_p2b = 0;
  endtask

  // One frame tick; pulses seen after the edge are tallied.
  task automatic tick(input logic [1:0] a, input logic [1:0] b);
    p1_state = a;
    p2_state = b;
    finished = 1'b1;
    @(posedge clk);
    #1;
    finished = 1'b0;
    n_p1h += int'(p1_hit);
    n_p2h += int'(p2_hit);
    n_p1b += int'(p1_blocked);
    n_p2b += int'(p2_blocked);
  endtask

  task automatic idle();
    finished = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    clr_pulses();
  endtask

  initial begin
    clr_pulses();
    #12;
    check("rst_p1_health", p1_health, 100);
    check("rst_p2_health", p2_health, 100);
    check("rst_game_state", game_state, 0);
    check("rst_pulses", {p1_hit, p2_hit, p1_blocked, p2_blocked}, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Basic hit: resolves on the 4th tick after entry.
    tick(2'b00, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick(2'b01, 2'b00);
      check($sformatf("t1_p2_hit_tick%0d", i), p2_hit, (i == 4) ? 1 : 0);
    end
    check("t1_p2_health", p2_health, 90);
    check("t1_p1_health", p1_health, 100);
    check("t1_game_state", game_state, 0);
    idle();
    check("t1_pulse_one_cycle", p2_hit, 0);
    clr_pulses();
    for (int i = 0; i < 6; i++) tick(2'b01, 2'b00);
    check("t1_held_no_rehit", n_p2h, 0);
    check("t1_health_after_hold", p2_health, 90);

    // Block on the resolving tick.
    do_restart();
    tick(2'b00, 2'b00);
    for (int i = 0; i < 4; i++) tick(2'b01, 2'b00);
    tick(2'b01, 2'b10);
    check("t2_p2_blocked", p2_blocked, 1);
    check("t2_p2_hit", n_p2h, 0);
    check("t2_p2_health", p2_health, 100);

    // Cancel then re-arm.
    do_restart();
    tick(2'b01, 2'b00);
    tick(2'b01, 2'b00);
    for (int i = 0; i < 5; i++) tick(2'b00, 2'b00);
    check("t3_cancel_pulses", n_p2h + n_p2b, 0);
    check("t3_cancel_health", p2_health, 100);
    for (int i = 0; i < 5; i++) tick(2'b01, 2'b00);
    check("t3_rearm_hits", n_p2h, 1);
    check("t3_rearm_health", p2_health, 90);

    // Simultaneous attacks.
    do_restart();
    for (int i = 0; i < 5; i++) tick(2'b01, 2'b01);
    check("t4_both_hit", {p1_hit, p2_hit}, 3);
    check("t4_p1_health", p1_health, 90);
    check("t4_p2_health", p2_health, 90);

    // Ten hits win the round for P1.
    do_restart();
    for (int k = 0; k < 10; k++) begin
      tick(2'b00, 2'b00);
      for (int i = 0; i < 5; i++) tick(2'b01, 2'b00);
      if (k == 8) begin
        check("t5_p2_health_h9", p2_health, 10);
        check("t5_state_h9", game_state, 0);
      end
    end
    check("t5_p2_health", p2_health, 0);
    check("t5_game_state", game_state, 1);
    clr_pulses();
    tick(2'b00, 2'b00);
    for (int i = 0; i < 5; i++) tick(2'b01, 2'b01);
    check("t5_frozen_pulses", n_p1h + n_p2h + n_p1b + n_p2b, 0);
    check("t5_frozen_p1", p1_health, 100);
    check("t5_frozen_state", game_state, 1);
    do_restart();
    check("t5_restart_p1", p1_health, 100);
    check("t5_restart_p2", p2_health, 100);
    check("t5_restart_state", game_state, 0);

    // Saturation and draw on the MAX_HEALTH=25 instance.
    for (int k = 0; k < 3; k++) begin
      tick(2'b00, 2'b00);
      for (int i = 0; i < 5; i++) tick(2'b01, 2'b01);
      if (k == 1) check("t6_sat_h_at5", s_p1_health + s_p2_health, 10);
    end
    check("t6_sat_p1", s_p1_health, 0);
    check("t6_sat_p2", s_p2_health, 0);
    check("t6_sat_draw", s_game_state, 3);
    check("t6_main_p1", p1_health, 70);

    // Async reset mid-windup.
    do_restart();
    tick(2'b00, 2'b00);
    for (int i = 0; i < 5; i++) tick(2'b01, 2'b00);
    tick(2'b00, 2'b00);
    tick(2'b01, 2'b00);
    tick(2'b01, 2'b00);
    #2;
    nrst = 1'b0;
    #1;
    check("t7_async_p2_health", p2_health, 100);
    check("t7_async_state", game_state, 0);
    @(negedge clk);
    nrst = 1'b1;
    clr_pulses();
    for (int i = 0; i < 3; i++) tick(2'b01, 2'b00);
    check("t7_no_pulse", n_p2h + n_p2b, 0);
    check("t7_p2_health", p2_health, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
